// File: rtl/retire_unit_pkg.sv
// Shared definitions for the commit stage: default widths, physical tag size
// and the retirement state encoding.
package retire_unit_pkg;

  localparam int RETIRE_WIDTH     = 2;
  localparam int PHYS_REG_SZ_R10K = 64;
  localparam int PHYS_TAG         = $clog2(PHYS_REG_SZ_R10K);
  localparam int ARCH_REG_COUNT   = 32;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    RECOVER = 2'd1,
    HALTED  = 2'd2
  } retire_state_e;

endpackage

// File: rtl/retire_unit_select.sv
// Prefix eligibility over the ROB head window: a lane retires only if every
// older lane retires and none of them ends the retire group.
module retire_select #(
  parameter  int N  = 2,
  localparam int CW = $clog2(N + 1)
) (
  input  logic          enable,
  input  logic [N-1:0]  valid,
  input  logic [N-1:0]  complete,
  input  logic [N-1:0]  mispredict,
  input  logic [N-1:0]  halt,
  output logic [N-1:0]  retire_mask,
  output logic [CW-1:0] retire_count
);

  logic chain_open;

  always_comb begin
    retire_mask  = '0;
    retire_count = '0;
    chain_open   = enable;
    for (int i = 0; i < N; i++) begin
      if (chain_open && valid[i] && complete[i]) begin
        retire_mask[i] = 1'b1;
        retire_count   = retire_count + CW'(1);
        // A branch or halt closes the group so it is always the youngest retired lane
        chain_open     = !mispredict[i] && !halt[i];
      end else begin
        chain_open = 1'b0;
      end
    end
  end

endmodule

// File: rtl/retire_unit.sv
// In-order N-wide commit stage: retires the completed ROB head prefix, keeps the
// precise architectural map and returns superseded tags to the freelist.
module retire_unit
  import retire_unit_pkg::*;
#(
  parameter  int N          = RETIRE_WIDTH,
  parameter  int PR_COUNT   = PHYS_REG_SZ_R10K,
  parameter  int ARCH_COUNT = ARCH_REG_COUNT,
  localparam int TW         = $clog2(PR_COUNT),
  localparam int AW         = $clog2(ARCH_COUNT),
  localparam int CW         = $clog2(N + 1)
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic [N-1:0]                   rob_valid,
  input  logic [N-1:0]                   rob_complete,
  input  logic [N-1:0]                   rob_has_dest,
  input  logic [N-1:0][AW-1:0]           rob_arch_dest,
  input  logic [N-1:0][TW-1:0]           rob_new_tag,
  input  logic [N-1:0][TW-1:0]           rob_old_tag,
  input  logic [N-1:0]                   rob_mispredict,
  input  logic [N-1:0]                   rob_halt,
  output logic [CW-1:0]                  retire_count,
  output logic [N-1:0]                   RetireEN,
  output logic [N-1:0][TW-1:0]           RetireReg,
  output logic                           BPRecoverEN,
  output logic [ARCH_COUNT-1:0][TW-1:0]  archi_maptable,
  output logic                           halted,
  output logic [31:0]                    retired_insts
);

  retire_state_e state, state_next;
  logic [N-1:0]  retire_mask;
  logic          select_enable;

  assign select_enable = reset_n && (state == RUN);

  retire_select #(.N(N)) u_select (
    .enable       (select_enable),
    .valid        (rob_valid),
    .complete     (rob_complete),
    .mispredict   (rob_mispredict),
    .halt         (rob_halt),
    .retire_mask  (retire_mask),
    .retire_count (retire_count)
  );

  always_comb begin
    RetireEN  = retire_mask & rob_has_dest;
    RetireReg = '0;
    for (int i = 0; i < N; i++) begin
      if (RetireEN[i]) RetireReg[i] = rob_old_tag[i];
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      RUN: begin
        // Halt outranks mispredict when one lane carries both
        if (|(retire_mask & rob_halt))            state_next = HALTED;
        else if (|(retire_mask & rob_mispredict)) state_next = RECOVER;
      end
      RECOVER: state_next = RUN;
      HALTED:  state_next = HALTED;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= RUN;
    else          state <= state_next;
  end

  assign BPRecoverEN = (state == RECOVER);
  assign halted      = (state == HALTED);

  // Ascending lane order lets the youngest writer of a duplicate destination win
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < ARCH_COUNT; r++) archi_maptable[r] <= TW'(r);
    end else begin
      for (int i = 0; i < N; i++) begin
        if (RetireEN[i]) archi_maptable[rob_arch_dest[i]] <= rob_new_tag[i];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) retired_insts <= '0;
    else          retired_insts <= retired_insts + 32'(retire_count);
  end

endmodule

// File: tb/tb_retire_unit.sv
// Scoreboard bench for retire_unit: directed commit scenarios followed by random
// ROB head traffic, checked against a lane-walking reference model.
module tb_retire_unit;

  localparam int N    = 2;
  localparam int TW   = 6;
  localparam int AW   = 5;
  localparam int ARCH = 32;
  localparam int CW   = 2;

  logic                     clock = 1'b0;
  logic                     reset_n = 1'b0;
  logic [N-1:0]             rob_valid = '0;
  logic [N-1:0]             rob_complete = '0;
  logic [N-1:0]             rob_has_dest = '0;
  logic [N-1:0][AW-1:0]     rob_arch_dest = '0;
  logic [N-1:0][TW-1:0]     rob_new_tag = '0;
  logic [N-1:0][TW-1:0]     rob_old_tag = '0;
  logic [N-1:0]             rob_mispredict = '0;
  logic [N-1:0]             rob_halt = '0;
  logic [CW-1:0]            retire_count;
  logic [N-1:0]             RetireEN;
  logic [N-1:0][TW-1:0]     RetireReg;
  logic                     BPRecoverEN;
  logic [ARCH-1:0][TW-1:0]  archi_maptable;
  logic                     halted;
  logic [31:0]              retired_insts;

  retire_unit #(.N(N), .PR_COUNT(64), .ARCH_COUNT(ARCH)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .rob_valid      (rob_valid),
    .rob_complete   (rob_complete),
    .rob_has_dest   (rob_has_dest),
    .rob_arch_dest  (rob_arch_dest),
    .rob_new_tag    (rob_new_tag),
    .rob_old_tag    (rob_old_tag),
    .rob_mispredict (rob_mispredict),
    .rob_halt       (rob_halt),
    .retire_count   (retire_count),
    .RetireEN       (RetireEN),
    .RetireReg      (RetireReg),
    .BPRecoverEN    (BPRecoverEN),
    .archi_maptable (archi_maptable),
    .halted         (halted),
    .retired_insts  (retired_insts)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    int                       count;
    logic [N-1:0]             en;
    logic [N-1:0][TW-1:0]     regs;
    logic                     rec;
    logic                     hlt;
    logic [31:0]              insts;
    logic [ARCH-1:0][TW-1:0]  map;
  } exp_t;

  exp_t q[$];
  int checks_total  = 0;
  int checks_passed = 0;

  // Reference model: precise map, pending recovery, halted flag, instruction count
  logic [ARCH-1:0][TW-1:0] m_map;
  bit                      m_rec;
  bit                      m_halted;
  logic [31:0]             m_insts;

  function automatic void check(string name, logic [255:0] act, logic [255:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  function automatic void model_reset();
    for (int r = 0; r < ARCH; r++) m_map[r] = TW'(r);
    m_rec    = 1'b0;
    m_halted = 1'b0;
    m_insts  = '0;
  endfunction

  task automatic apply_stimulus(input logic [N-1:0] v, input logic [N-1:0] c,
                                input logic [N-1:0] hd, input logic [N-1:0] mp,
                                input logic [N-1:0] ht,
                                input logic [N-1:0][AW-1:0] ad,
                                input logic [N-1:0][TW-1:0] nt,
                                input logic [N-1:0][TW-1:0] ot);
    exp_t e;
    bit   new_rec;
    @(posedge clock);
    #1;
    reset_n        = 1'b1;
    rob_valid      = v;
    rob_complete   = c;
    rob_has_dest   = hd;
    rob_mispredict = mp;
    rob_halt       = ht;
    rob_arch_dest  = ad;
    rob_new_tag    = nt;
    rob_old_tag    = ot;
    e.count = 0;
    e.en    = '0;
    e.regs  = '0;
    e.rec   = m_rec;
    e.hlt   = m_halted;
    e.insts = m_insts;
    e.map   = m_map;
    if (!m_rec && !m_halted) begin
      for (int i = 0; i < N; i++) begin
        if (!(v[i] && c[i])) break;
        e.count++;
        if (mp[i] || ht[i]) break;
      end
    end
    new_rec = 1'b0;
    for (int i = 0; i < e.count; i++) begin
      if (hd[i]) begin
        e.en[i]       = 1'b1;
        e.regs[i]     = ot[i];
        m_map[ad[i]]  = nt[i];
      end
      if (ht[i])      m_halted = 1'b1;
      else if (mp[i]) new_rec  = 1'b1;
    end
    m_rec   = new_rec;
    m_insts = m_insts + 32'(e.count);
    q.push_back(e);
  endtask

  task automatic apply_reset();
    exp_t e;
    @(posedge clock);
    #1;
    reset_n = 1'b0;
    model_reset();
    e.count = 0;
    e.en    = '0;
    e.regs  = '0;
    e.rec   = 1'b0;
    e.hlt   = 1'b0;
    e.insts = '0;
    e.map   = m_map;
    q.push_back(e);
  endtask

  task automatic random_cycle();
    logic [N-1:0]         v, c, hd, mp, ht;
    logic [N-1:0][AW-1:0] ad;
    logic [N-1:0][TW-1:0] nt, ot;
    for (int i = 0; i < N; i++) begin
      v[i]  = ($urandom_range(0, 99) < 85);
      c[i]  = ($urandom_range(0, 99) < 75);
      mp[i] = ($urandom_range(0, 99) < 10);
      ht[i] = ($urandom_range(0, 99) < 2);
      ad[i] = AW'($urandom_range(0, ARCH - 1));
      hd[i] = ($urandom_range(0, 3) != 0) && (ad[i] != '0);
      nt[i] = TW'($urandom_range(0, 63));
      ot[i] = TW'($urandom_range(0, 63));
    end
    apply_stimulus(v, c, hd, mp, ht, ad, nt, ot);
  endtask

  // Monitor: every falling edge compares the DUT against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("retire_count",  256'(retire_count),   256'(e.count));
        check("RetireEN",      256'(RetireEN),       256'(e.en));
        check("RetireReg",     256'(RetireReg),      256'(e.regs));
        check("BPRecoverEN",   256'(BPRecoverEN),    256'(e.rec));
        check("halted",        256'(halted),         256'(e.hlt));
        check("retired_insts", 256'(retired_insts),  256'(e.insts));
        check("archi_maptable", 256'(archi_maptable), 256'(e.map));
      end
    end
  end

  initial begin
    int halt_cycles;
    model_reset();
    apply_reset();
    // Two independent destinations retire together
    apply_stimulus(2'b11, 2'b11, 2'b11, 2'b00, 2'b00, {5'd7, 5'd3}, {6'd41, 6'd40}, {6'd7, 6'd3});
    // Oldest lane incomplete blocks the younger one
    apply_stimulus(2'b11, 2'b10, 2'b11, 2'b00, 2'b00, {5'd9, 5'd8}, {6'd43, 6'd42}, {6'd9, 6'd8});
    // Mispredicted branch retires alone, then the recovery cycle ignores the ROB
    apply_stimulus(2'b11, 2'b11, 2'b10, 2'b01, 2'b00, {5'd2, 5'd0}, {6'd44, 6'd0}, {6'd2, 6'd0});
    apply_stimulus(2'b11, 2'b11, 2'b11, 2'b00, 2'b00, {5'd11, 5'd10}, {6'd46, 6'd45}, {6'd11, 6'd10});
    apply_stimulus(2'b11, 2'b11, 2'b11, 2'b00, 2'b00, {5'd11, 5'd10}, {6'd46, 6'd45}, {6'd11, 6'd10});
    // Same destination in both lanes: youngest mapping survives
    apply_stimulus(2'b11, 2'b11, 2'b11, 2'b00, 2'b00, {5'd4, 5'd4}, {6'd51, 6'd50}, {6'd50, 6'd4});
    // Halt retires, then the unit stays quiet until reset
    apply_stimulus(2'b11, 2'b11, 2'b10, 2'b00, 2'b01, {5'd12, 5'd0}, {6'd52, 6'd0}, {6'd12, 6'd0});
    apply_stimulus(2'b11, 2'b11, 2'b11, 2'b00, 2'b00, {5'd13, 5'd14}, {6'd53, 6'd54}, {6'd13, 6'd14});
    apply_stimulus(2'b11, 2'b11, 2'b11, 2'b00, 2'b00, {5'd13, 5'd14}, {6'd53, 6'd54}, {6'd13, 6'd14});
    apply_reset();
    // Mispredict and halt on one lane: halt wins
    apply_stimulus(2'b01, 2'b01, 2'b00, 2'b01, 2'b01, {5'd0, 5'd0}, {6'd0, 6'd0}, {6'd0, 6'd0});
    apply_stimulus(2'b11, 2'b11, 2'b00, 2'b00, 2'b00, {5'd0, 5'd0}, {6'd0, 6'd0}, {6'd0, 6'd0});
    apply_reset();

    halt_cycles = 0;
    for (int k = 0; k < 600; k++) begin
      if (m_halted) halt_cycles++;
      if (halt_cycles > 3 || $urandom_range(0, 99) == 0) begin
        halt_cycles = 0;
        apply_reset();
      end else begin
        random_cycle();
      end
    end

    for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clock);
    if (q.size() != 0) begin
      checks_total++;
      $display("[TB] FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
